// File: rtl/permutation_ctrl_pkg.sv
// Shared types and constants for the ASCON permutation controller.
// Round indices run up to LAST_ROUND regardless of the round count.
package permutation_ctrl_pkg;

  localparam logic [3:0] LAST_ROUND = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ROUND,
    DONE
  } type_perm_ctrl_state;

  function automatic logic [3:0] first_round(input int unsigned rounds);
    return 4'(12 - rounds);
  endfunction

endpackage

// File: rtl/permutation_ctrl_round_counter.sv
// 4-bit round index counter with synchronous load and increment.
// last_o flags the final ASCON round index.
module round_counter
  import permutation_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       inc_i,
  input  logic [3:0] init_i,
  output logic [3:0] value_o,
  output logic       last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = init_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign last_o  = (cnt_q == LAST_ROUND);

endmodule

// File: rtl/permutation_ctrl.sv
// Control FSM sequencing the ASCON permutation for p^a or p^b runs.
// All outputs come straight from flops; round_o is the counter register.
module permutation_ctrl
  import permutation_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic [3:0] round_o,
  output logic       enable_o,
  output logic       sel_mux_o,
  output logic       busy_o,
  output logic       done_o
);

  type_perm_ctrl_state state_q, state_d;

  logic enable_q, enable_d;
  logic sel_mux_q, sel_mux_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic       cnt_load;
  logic       cnt_inc;
  logic       cnt_last;
  logic       cnt_bad;
  logic [3:0] cnt_init;
  logic [3:0] cnt_value;

  round_counter u_round_counter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (cnt_load),
    .inc_i   (cnt_inc),
    .init_i  (cnt_init),
    .value_o (cnt_value),
    .last_o  (cnt_last)
  );

  assign cnt_init = mode_i ? first_round(ROUNDS_B)
                           : first_round(ROUNDS_A);
  assign cnt_bad  = (cnt_value > LAST_ROUND);

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = INIT;
          cnt_load = 1'b1;
        end
      end
      INIT: begin
        state_d = ROUND;
        cnt_inc = 1'b1;
      end
      ROUND: begin
        // An out-of-range index can only come from corruption; bail out.
        if (cnt_bad) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    enable_d  = 1'b0;
    sel_mux_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (1'b1)
      (state_d == INIT): begin
        enable_d = 1'b1;
        busy_d   = 1'b1;
      end
      (state_d == ROUND): begin
        enable_d  = 1'b1;
        sel_mux_d = 1'b1;
        busy_d    = 1'b1;
      end
      (state_d == DONE): begin
        sel_mux_d = 1'b1;
        done_d    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      sel_mux_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      sel_mux_q <= sel_mux_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign round_o   = cnt_value;
  assign enable_o  = enable_q;
  assign sel_mux_o = sel_mux_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  param_ok_a : assert property (@(posedge clock_i)
    (ROUNDS_A inside {[1:12]}) && (ROUNDS_B inside {[1:12]}));

endmodule

// File: tb/tb_permutation_ctrl.sv
// Directed bench for permutation_ctrl: vector table plus
// hand-written reset-abort sequence.
module tb_permutation_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic       mode_i;
  logic [3:0] round_o;
  logic       enable_o;
  logic       sel_mux_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       start;
    logic       mode;
    logic [3:0] round;
    logic       en;
    logic       sel;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  permutation_ctrl #(
    .ROUNDS_A(12),
    .ROUNDS_B(6)
  ) dut (
    .clock_i  (clk),
    .reset_i  (rst_n),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .round_o  (round_o),
    .enable_o (enable_o),
    .sel_mux_o(sel_mux_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic push(input logic s, input logic m,
                      input logic [3:0] r, input logic e,
                      input logic sl, input logic b,
                      input logic d);
    vec_t v;
    v.start = s;
    v.mode  = m;
    v.round = r;
    v.en    = e;
    v.sel   = sl;
    v.busy  = b;
    v.done  = d;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] r,
                       input logic e, input logic sl,
                       input logic b, input logic d);
    checks++;
    if ({round_o, enable_o, sel_mux_o, busy_o, done_o}
        !== {r, e, sl, b, d}) begin
      errors++;
      $display("FAIL %s: got round=%0d en=%b sel=%b busy=%b done=%b, want round=%0d en=%b sel=%b busy=%b done=%b",
               name, round_o, enable_o, sel_mux_o, busy_o, done_o,
               r, e, sl, b, d);
    end
  endtask

  task automatic step(input logic s, input logic m);
    start_i = s;
    mode_i  = m;
    @(posedge clk);
    #1;
  endtask

  // Expected p^12 run starting from IDLE; opt. start pulse at round 5.
  task automatic push_p12(input logic poke);
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      push((poke && i == 6), 1'b1, 4'(i), 1'b1, 1'b1, 1'b1, 1'b0);
    end
    push(1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0, 1'b1);
    push(poke, poke, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    mode_i  = 1'b0;
    #2;
    check("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    push_p12(1'b0);
    push(1'b0, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 7; i <= 11; i++) begin
      push(1'b0, 1'b0, 4'(i), 1'b1, 1'b1, 1'b1, 1'b0);
    end
    push(1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_p12(1'b1);
    push(1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].mode);
      check($sformatf("vec%0d", i), tbl[i].round, tbl[i].en,
            tbl[i].sel, tbl[i].busy, tbl[i].done);
    end

    // Abort a p^12 run at round 7 with an asynchronous reset.
    step(1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0);
    end
    check("pre_abort_r7", 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_immediate", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      check("abort_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    check("abort_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b0);
    check("fresh_init", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("fresh_r%0d", i), 4'(i),
            1'b1, 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    check("fresh_done", 4'd11, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("fresh_idle", 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
